// File: rtl/types_def.sv
// rtl/types_def.sv - shared types, opcodes and error codes for the DDR5 command responder
package types_def;

    localparam int data_width = 8;
    localparam int NUM_BANKS  = 16;

    localparam logic [1:0] OP_ACT = 2'b00;
    localparam logic [4:0] OP_RD  = 5'b11101;
    localparam logic [4:0] OP_WR  = 5'b01101;
    localparam logic [5:0] OP_PRE = 6'b011011;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CLOSED   = 2'd1;
    localparam logic [1:0] ERR_OPEN     = 2'd2;
    localparam logic [1:0] ERR_CONFLICT = 2'd3;

    typedef enum logic [2:0] {CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_ILL} cmd_t;

    typedef struct packed {
        logic        is_open;
        logic [15:0] row;
    } bank_state_t;

    typedef enum logic [1:0] {IDLE, CMD2, WAIT, DATA} state_t;

    function automatic cmd_t decode_cmd(input logic [5:0] c);
        cmd_t r;
        if (c[1:0] == OP_ACT)      r = CMD_ACT;
        else if (c[4:0] == OP_RD)  r = CMD_RD;
        else if (c[4:0] == OP_WR)  r = CMD_WR;
        else if (c[5:0] == OP_PRE) r = CMD_PRE;
        else                       r = CMD_ILL;
        return r;
    endfunction

endpackage

// File: rtl/ddr5_cmd_responder_if.sv
// rtl/ddr5_cmd_responder_if.sv - command/data bus between controller and responder
interface ddr5_cmd_responder_if;
    import types_def::*;

    logic                  cs_n;
    logic [13:0]           ca;
    logic [data_width-1:0] dq_in;
    logic [data_width-1:0] dq_out;
    logic                  dq_oe;
    logic                  alert_n;
    logic [1:0]            err_code;
    logic                  busy;

    modport master (output cs_n, ca, dq_in, input dq_out, dq_oe, alert_n, err_code, busy);
    modport slave  (input cs_n, ca, dq_in, output dq_out, dq_oe, alert_n, err_code, busy);
endinterface

// File: rtl/ddr5_resp_mem.sv
// rtl/ddr5_resp_mem.sv - single-port synchronous RAM, one-cycle read latency
module ddr5_resp_mem #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

// File: rtl/ddr5_cmd_responder.sv
// rtl/ddr5_cmd_responder.sv - DDR5 device-side command decoder with bank tracking and burst data path
module ddr5_cmd_responder
    import types_def::*;
#(
    parameter int RD_LAT    = 11,
    parameter int WR_LAT    = 8,
    parameter int BURST_LEN = 16,
    parameter int ROW_BITS  = 1
) (
    input logic clk,
    input logic rst_n,
    ddr5_cmd_responder_if.slave bus
);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int BEAT_W  = $clog2(BURST_LEN);
    localparam int ADDR_W  = 4 + ROW_BITS + 6 + 4;
    // Reads exit WAIT at RD_LAT because the RAM read is issued a cycle early;
    // writes enter DATA one cycle before the first sample edge.
    localparam logic [LAT_W-1:0]  RD_THR    = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0]  WR_THR    = LAT_W'(WR_LAT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    state_t            state;
    bank_state_t       banks [NUM_BANKS];
    logic              second;
    cmd_t              c2_cmd;
    logic              c2_ok;
    logic [3:0]        c2_bank;
    logic [3:0]        c2_row_lo;
    logic [3:0]        burst_bank;
    logic [15:0]       burst_row;
    logic [5:0]        burst_col;
    logic              burst_ap_bar;
    logic              burst_rd;
    logic [LAT_W-1:0]  lat_cnt;
    logic [BEAT_W-1:0] beat;
    logic              dq_oe_r;
    logic              alert_n_r;
    logic              busy_r;
    logic [1:0]        err_code_r;

    cmd_t              cmd1;
    logic [3:0]        cmd_bank;
    logic              in_burst;
    logic              hit_burst;
    logic              two_cycle;
    logic              new_cmd;
    logic [1:0]        cmd_err;
    logic              c2_is_rd;

    logic              rd_issue;
    logic              wr_issue;
    logic [BEAT_W-1:0] mem_beat;
    logic [ADDR_W-1:0] mem_addr;
    logic [data_width-1:0] mem_rdata;

    logic unused_ca;
    logic unused_row;
    assign unused_ca  = ^bus.ca[13:12];
    assign unused_row = ^burst_row;

    assign cmd1      = decode_cmd(bus.ca[5:0]);
    assign cmd_bank  = bus.ca[9:6];
    assign in_burst  = (state == WAIT) || (state == DATA);
    assign hit_burst = in_burst && (cmd_bank == burst_bank);
    assign two_cycle = cmd1 inside {CMD_ACT, CMD_RD, CMD_WR};
    assign new_cmd   = !second && !bus.cs_n;
    assign c2_is_rd  = (c2_cmd == CMD_RD);

    always_comb begin
        cmd_err = ERR_NONE;
        case (cmd1)
            CMD_RD, CMD_WR: begin
                if (in_burst)                     cmd_err = ERR_CONFLICT;
                else if (!banks[cmd_bank].is_open) cmd_err = ERR_CLOSED;
            end
            CMD_ACT: begin
                if (hit_burst)                   cmd_err = ERR_CONFLICT;
                else if (banks[cmd_bank].is_open) cmd_err = ERR_OPEN;
            end
            CMD_PRE: begin
                if (hit_burst) cmd_err = ERR_CONFLICT;
            end
            default: cmd_err = ERR_CONFLICT;
        endcase
    end

    always_comb begin
        rd_issue = burst_rd && (((state == WAIT) && (lat_cnt == RD_THR)) ||
                                ((state == DATA) && (beat != BEAT_LAST)));
        wr_issue = !burst_rd && (state == DATA);
        mem_beat = '0;
        if (state == DATA) mem_beat = burst_rd ? beat + 1'b1 : beat;
        mem_addr = {burst_bank, burst_row[ROW_BITS-1:0], burst_col, 4'(mem_beat)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            second       <= 1'b0;
            c2_cmd       <= CMD_ILL;
            c2_ok        <= 1'b0;
            c2_bank      <= '0;
            c2_row_lo    <= '0;
            burst_bank   <= '0;
            burst_row    <= '0;
            burst_col    <= '0;
            burst_ap_bar <= 1'b1;
            burst_rd     <= 1'b0;
            lat_cnt      <= '0;
            beat         <= '0;
            dq_oe_r      <= 1'b0;
            alert_n_r    <= 1'b1;
            err_code_r   <= ERR_NONE;
            busy_r       <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) banks[i] <= '0;
        end else begin
            alert_n_r <= 1'b1;
            second    <= 1'b0;
            if (second) begin
                if (c2_ok && (c2_cmd == CMD_ACT))
                    banks[c2_bank] <= '{is_open: 1'b1, row: {bus.ca[11:0], c2_row_lo}};
            end else if (!bus.cs_n) begin
                if (cmd_err != ERR_NONE) begin
                    alert_n_r  <= 1'b0;
                    err_code_r <= cmd_err;
                end
                // Rejected two-cycle commands still swallow their second cycle.
                if (two_cycle) begin
                    second    <= 1'b1;
                    c2_cmd    <= cmd1;
                    c2_ok     <= (cmd_err == ERR_NONE);
                    c2_bank   <= cmd_bank;
                    c2_row_lo <= bus.ca[5:2];
                end else if ((cmd1 == CMD_PRE) && (cmd_err == ERR_NONE)) begin
                    banks[cmd_bank].is_open <= 1'b0;
                end
            end

            case (state)
                IDLE: if (new_cmd && two_cycle) state <= CMD2;
                CMD2: begin
                    if (c2_ok && (c2_cmd inside {CMD_RD, CMD_WR})) begin
                        state        <= WAIT;
                        busy_r       <= 1'b1;
                        lat_cnt      <= LAT_W'(1);
                        burst_rd     <= c2_is_rd;
                        burst_bank   <= c2_bank;
                        burst_row    <= banks[c2_bank].row;
                        burst_col    <= c2_is_rd ? bus.ca[7:2] : bus.ca[6:1];
                        burst_ap_bar <= c2_is_rd ? bus.ca[9] : bus.ca[8];
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_cnt == (burst_rd ? RD_THR : WR_THR)) begin
                        state   <= DATA;
                        beat    <= '0;
                        dq_oe_r <= burst_rd;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (beat == BEAT_LAST) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        dq_oe_r <= 1'b0;
                        if (!burst_ap_bar) banks[burst_bank].is_open <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ddr5_resp_mem #(.ADDR_W(ADDR_W), .DATA_W(data_width)) u_mem (
        .clk   (clk),
        .en    (rd_issue || wr_issue),
        .we    (wr_issue),
        .addr  (mem_addr),
        .wdata (bus.dq_in),
        .rdata (mem_rdata)
    );

    assign bus.dq_out   = dq_oe_r ? mem_rdata : '0;
    assign bus.dq_oe    = dq_oe_r;
    assign bus.alert_n  = alert_n_r;
    assign bus.err_code = err_code_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// tb/tb_ddr5_cmd_responder.sv - directed self-checking bench for ddr5_cmd_responder
module tb_ddr5_cmd_responder;
    import types_def::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr5_cmd_responder_if bus();

    ddr5_cmd_responder #(.RD_LAT(11), .WR_LAT(8), .BURST_LEN(16), .ROW_BITS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [13:0] CA_ILL = 14'h0003;

    int checks = 0;
    int failures = 0;
    int alert_lows = 0;
    int oe_cycles = 0;

    task automatic tick;
        @(posedge clk);
        #1;
        if (bus.alert_n === 1'b0) alert_lows++;
        if (bus.dq_oe === 1'b1) oe_cycles++;
    endtask

    function automatic logic [13:0] act_c1(input logic [1:0] bg, input logic [1:0] bk, input logic [15:0] row);
        return {4'b0, bg, bk, row[3:0], 2'b00};
    endfunction
    function automatic logic [13:0] act_c2(input logic [15:0] row);
        return {2'b0, row[15:4]};
    endfunction
    function automatic logic [13:0] rd_c1(input logic [1:0] bg, input logic [1:0] bk);
        return {4'b0, bg, bk, 6'b011101};
    endfunction
    function automatic logic [13:0] rd_c2(input logic [5:0] col, input logic ap_bar);
        return {4'b0, ap_bar, 1'b0, col, 2'b00};
    endfunction
    function automatic logic [13:0] wr_c1(input logic [1:0] bg, input logic [1:0] bk);
        return {4'b0, bg, bk, 6'b001101};
    endfunction
    function automatic logic [13:0] wr_c2(input logic [5:0] col, input logic ap_bar);
        return {5'b0, ap_bar, 1'b0, col, 1'b0};
    endfunction
    function automatic logic [13:0] pre_c1(input logic [1:0] bg, input logic [1:0] bk);
        return {4'b0, bg, bk, 6'b011011};
    endfunction

    // Returns just after the posedge that samples cycle 2.
    task automatic send2(input logic [13:0] c1, input logic [13:0] c2);
        bus.cs_n = 1'b0;
        bus.ca   = c1;
        tick;
        bus.cs_n = 1'b1;
        bus.ca   = c2;
        tick;
        bus.ca   = '0;
    endtask

    task automatic write_burst(input logic [7:0] base);
        repeat (7) tick;
        for (int k = 0; k < 16; k++) begin
            bus.dq_in = 8'(base + k);
            tick;
        end
        bus.dq_in = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.cs_n = 1'b1;
        bus.ca = '0;
        bus.dq_in = '0;
        repeat (3) tick;
        checks += 5;
        if (bus.dq_oe !== 1'b0) begin failures++; $display("FAIL reset_dq_oe got=%b exp=0", bus.dq_oe); end
        if (bus.dq_out !== 8'h00) begin failures++; $display("FAIL reset_dq_out got=%h exp=00", bus.dq_out); end
        if (bus.alert_n !== 1'b1) begin failures++; $display("FAIL reset_alert_n got=%b exp=1", bus.alert_n); end
        if (bus.err_code !== 2'd0) begin failures++; $display("FAIL reset_err_code got=%0d exp=0", bus.err_code); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_write_read;
        logic exp_oe;
        logic [7:0] exp_d;
        alert_lows = 0;
        send2(act_c1(2'd1, 2'd2, 16'h0005), act_c2(16'h0005));
        send2(wr_c1(2'd1, 2'd2), wr_c2(6'd3, 1'b1));
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL wr_busy_high got=%b exp=1", bus.busy); end
        write_burst(8'hA0);
        checks += 2;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL wr_busy_low got=%b exp=0", bus.busy); end
        if (alert_lows != 0) begin failures++; $display("FAIL wr_no_alert got=%0d exp=0", alert_lows); end
        send2(rd_c1(2'd1, 2'd2), rd_c2(6'd3, 1'b1));
        for (int j = 1; j <= 30; j++) begin
            tick;
            exp_oe = (j >= 11) && (j <= 26);
            exp_d  = exp_oe ? 8'(8'hA0 + j - 11) : 8'h00;
            checks += 2;
            if (bus.dq_oe !== exp_oe) begin failures++; $display("FAIL wr_rd_oe j=%0d got=%b exp=%b", j, bus.dq_oe, exp_oe); end
            if (bus.dq_out !== exp_d) begin failures++; $display("FAIL wr_rd_data j=%0d got=%h exp=%h", j, bus.dq_out, exp_d); end
        end
    endtask

    task automatic test_closed_bank;
        alert_lows = 0;
        oe_cycles = 0;
        send2(rd_c1(2'd1, 2'd0), rd_c2(6'd0, 1'b1));
        repeat (30) tick;
        checks += 4;
        if (alert_lows != 1) begin failures++; $display("FAIL closed_alert_pulses got=%0d exp=1", alert_lows); end
        if (bus.err_code !== 2'd1) begin failures++; $display("FAIL closed_err_code got=%0d exp=1", bus.err_code); end
        if (oe_cycles != 0) begin failures++; $display("FAIL closed_oe_cycles got=%0d exp=0", oe_cycles); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL closed_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_act_open;
        send2(act_c1(2'd0, 2'd0, 16'h1234), act_c2(16'h1234));
        send2(wr_c1(2'd0, 2'd0), wr_c2(6'd0, 1'b1));
        write_burst(8'h50);
        alert_lows = 0;
        send2(act_c1(2'd0, 2'd0, 16'h0777), act_c2(16'h0777));
        tick;
        checks += 2;
        if (alert_lows != 1) begin failures++; $display("FAIL act_open_alert got=%0d exp=1", alert_lows); end
        if (bus.err_code !== 2'd2) begin failures++; $display("FAIL act_open_err_code got=%0d exp=2", bus.err_code); end
    endtask

    task automatic test_autoprecharge;
        logic exp_oe;
        logic [7:0] exp_d;
        send2(rd_c1(2'd0, 2'd0), rd_c2(6'd0, 1'b0));
        for (int j = 1; j <= 30; j++) begin
            tick;
            exp_oe = (j >= 11) && (j <= 26);
            exp_d  = exp_oe ? 8'(8'h50 + j - 11) : 8'h00;
            checks += 2;
            if (bus.dq_oe !== exp_oe) begin failures++; $display("FAIL ap_rd_oe j=%0d got=%b exp=%b", j, bus.dq_oe, exp_oe); end
            if (bus.dq_out !== exp_d) begin failures++; $display("FAIL ap_rd_data j=%0d got=%h exp=%h", j, bus.dq_out, exp_d); end
        end
        alert_lows = 0;
        oe_cycles = 0;
        send2(rd_c1(2'd0, 2'd0), rd_c2(6'd0, 1'b1));
        repeat (30) tick;
        checks += 3;
        if (bus.err_code !== 2'd1) begin failures++; $display("FAIL ap_closed_err got=%0d exp=1", bus.err_code); end
        if (alert_lows != 1) begin failures++; $display("FAIL ap_closed_alert got=%0d exp=1", alert_lows); end
        if (oe_cycles != 0) begin failures++; $display("FAIL ap_closed_oe got=%0d exp=0", oe_cycles); end
    endtask

    task automatic test_busy_write;
        logic exp_oe;
        logic [7:0] exp_d;
        alert_lows = 0;
        send2(rd_c1(2'd1, 2'd2), rd_c2(6'd3, 1'b1));
        bus.dq_in = 8'hFF;
        for (int j = 1; j <= 30; j++) begin
            if (j == 4) begin bus.cs_n = 1'b0; bus.ca = wr_c1(2'd1, 2'd2); end
            else if (j == 5) begin bus.cs_n = 1'b1; bus.ca = wr_c2(6'd0, 1'b1); end
            else if (j == 27) begin bus.cs_n = 1'b0; bus.ca = CA_ILL; end
            else begin bus.cs_n = 1'b1; bus.ca = '0; end
            tick;
            exp_oe = (j >= 11) && (j <= 26);
            exp_d  = exp_oe ? 8'(8'hA0 + j - 11) : 8'h00;
            checks += 2;
            if (bus.dq_oe !== exp_oe) begin failures++; $display("FAIL busy_rd_oe j=%0d got=%b exp=%b", j, bus.dq_oe, exp_oe); end
            if (bus.dq_out !== exp_d) begin failures++; $display("FAIL busy_rd_data j=%0d got=%h exp=%h", j, bus.dq_out, exp_d); end
            if (j == 4 || j == 27) begin
                checks += 2;
                if (bus.alert_n !== 1'b0) begin failures++; $display("FAIL busy_alert j=%0d got=%b exp=0", j, bus.alert_n); end
                if (bus.err_code !== 2'd3) begin failures++; $display("FAIL busy_err_code j=%0d got=%0d exp=3", j, bus.err_code); end
            end
        end
        bus.dq_in = '0;
        checks++;
        if (alert_lows != 2) begin failures++; $display("FAIL busy_alert_pulses got=%0d exp=2", alert_lows); end
    endtask

    task automatic test_background;
        logic exp_oe;
        logic [7:0] exp_d;
        alert_lows = 0;
        send2(rd_c1(2'd1, 2'd2), rd_c2(6'd3, 1'b1));
        for (int j = 1; j <= 30; j++) begin
            if (j == 2) begin bus.cs_n = 1'b0; bus.ca = act_c1(2'd0, 2'd3, 16'h0042); end
            else if (j == 3) begin bus.cs_n = 1'b1; bus.ca = act_c2(16'h0042); end
            else if (j == 8) begin bus.cs_n = 1'b0; bus.ca = pre_c1(2'd1, 2'd2); end
            else begin bus.cs_n = 1'b1; bus.ca = '0; end
            tick;
            exp_oe = (j >= 11) && (j <= 26);
            exp_d  = exp_oe ? 8'(8'hA0 + j - 11) : 8'h00;
            checks += 2;
            if (bus.dq_oe !== exp_oe) begin failures++; $display("FAIL bg_rd_oe j=%0d got=%b exp=%b", j, bus.dq_oe, exp_oe); end
            if (bus.dq_out !== exp_d) begin failures++; $display("FAIL bg_rd_data j=%0d got=%h exp=%h", j, bus.dq_out, exp_d); end
            if (j == 8) begin
                checks++;
                if (bus.err_code !== 2'd3) begin failures++; $display("FAIL bg_pre_err got=%0d exp=3", bus.err_code); end
            end
        end
        checks++;
        if (alert_lows != 1) begin failures++; $display("FAIL bg_alert_pulses got=%0d exp=1", alert_lows); end
        alert_lows = 0;
        send2(act_c1(2'd0, 2'd3, 16'h0042), act_c2(16'h0042));
        tick;
        checks += 2;
        if (alert_lows != 1) begin failures++; $display("FAIL bg_act_reopen_alert got=%0d exp=1", alert_lows); end
        if (bus.err_code !== 2'd2) begin failures++; $display("FAIL bg_act_reopen_err got=%0d exp=2", bus.err_code); end
    endtask

    task automatic test_reset_mid_burst;
        send2(rd_c1(2'd1, 2'd2), rd_c2(6'd3, 1'b1));
        for (int j = 1; j <= 16; j++) tick;
        checks += 2;
        if (bus.dq_oe !== 1'b1) begin failures++; $display("FAIL rst_beat5_oe got=%b exp=1", bus.dq_oe); end
        if (bus.dq_out !== 8'hA5) begin failures++; $display("FAIL rst_beat5_data got=%h exp=a5", bus.dq_out); end
        rst_n = 1'b0;
        tick;
        checks += 4;
        if (bus.dq_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_oe got=%b exp=0", bus.dq_oe); end
        if (bus.dq_out !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", bus.dq_out); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        if (bus.err_code !== 2'd0) begin failures++; $display("FAIL rst_mid_err got=%0d exp=0", bus.err_code); end
        rst_n = 1'b1;
        tick;
        alert_lows = 0;
        oe_cycles = 0;
        send2(rd_c1(2'd1, 2'd2), rd_c2(6'd3, 1'b1));
        repeat (30) tick;
        checks += 3;
        if (bus.err_code !== 2'd1) begin failures++; $display("FAIL rst_bank_closed_err got=%0d exp=1", bus.err_code); end
        if (oe_cycles != 0) begin failures++; $display("FAIL rst_bank_closed_oe got=%0d exp=0", oe_cycles); end
        if (alert_lows != 1) begin failures++; $display("FAIL rst_bank_closed_alert got=%0d exp=1", alert_lows); end
    endtask

    initial begin
        bus.cs_n  = 1'b1;
        bus.ca    = '0;
        bus.dq_in = '0;
        test_reset;
        test_write_read;
        test_closed_bank;
        test_act_open;
        test_autoprecharge;
        test_busy_write;
        test_background;
        test_reset_mid_burst;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
